// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions.
//   NR         : default round count (round-key storage holds NR+1 entries)
//   NK         : key length in 32-bit words
//   RCON_INIT  : first round constant
//   XTIME_POLY : GF(2^8) reduction term applied by xtime
//   ksState_t  : key-schedule FSM states
//   xtime()    : multiply by x in GF(2^8)
package aes_pkg;

  localparam int         NR         = 10;
  localparam int         NK         = 4;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    FINISH
  } ksState_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   din  : input byte
//   dout : SubBytes(din)
// Computed as multiplicative inverse in GF(2^8) followed by the affine map,
// rather than a 256-entry table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = din^254 = din^(2+4+...+128); 0 maps to 0 as required.
  always_comb begin
    sq  = din;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
  end

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key expansion, one round key per clock.
//   clk, rst_n  : clock, synchronous active-low reset
//   key_in      : cipher key (key_in[127:96] = w0)
//   key_valid   : key offered; key_ready : key accepted this cycle when both high
//   busy        : expansion in progress
//   done        : one-cycle pulse once rk[NR] is stored
//   keys_valid  : stored round-key set complete; held until next accept/reset
//   rk_idx      : read index; rk_out : rk[rk_idx] or zero when invalid/out of range
module key_schedule_seq #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);
  import aes_pkg::*;

  // Round counter parks at NR+1 after the last write, so size for that.
  localparam int RW = $clog2(NR + 2);

  ksState_t             state, stateNext;
  logic [RW-1:0]        round;
  logic [7:0]           rcon;
  logic                 keysValidQ;
  logic [127:0]         rkMem [NR:0];

  logic                 accept;
  logic                 lastRound;
  logic [NK-1:0][31:0]  prevW;
  logic [NK-1:0][31:0]  nextW;
  logic [31:0]          rotW;
  logic [31:0]          subW;
  logic [31:0]          tW;

  assign accept    = (state == IDLE) && key_valid;
  assign lastRound = (round == RW'(NR));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) stateNext = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (lastRound) stateNext = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // ---------------- round / rcon / keys_valid ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round      <= '0;
      rcon       <= RCON_INIT;
      keysValidQ <= 1'b0;
    end else if (accept) begin
      round      <= RW'(1);
      rcon       <= RCON_INIT;
      keysValidQ <= 1'b0;
    end else if (state == EXPAND) begin
      round <= round + RW'(1);
      rcon  <= xtime(rcon);
      // Raised together with the rk[NR] write so it is high during FINISH.
      if (lastRound) keysValidQ <= 1'b1;
    end
  end

  assign keys_valid = keysValidQ;

  // ---------------- round function ----------------
  assign prevW = rkMem[round - RW'(1)];
  assign rotW  = {prevW[0][23:0], prevW[0][31:24]};

  for (genvar g = 0; g < 4; g++) begin : gSbox
    aes_sbox uSbox (
      .din  (rotW[8*g +: 8]),
      .dout (subW[8*g +: 8])
    );
  end

  assign tW = subW ^ {rcon, 24'h0};

  // prevW[NK-1] is w0; each following word chains off the new previous word.
  always_comb begin
    nextW[NK-1] = prevW[NK-1] ^ tW;
    for (int i = NK - 2; i >= 0; i--) begin
      nextW[i] = prevW[i] ^ nextW[i+1];
    end
  end

  // ---------------- storage (no reset; masked by keys_valid) ----------------
  always_ff @(posedge clk) begin
    if (accept)                rkMem[0]     <= key_in;
    else if (state == EXPAND)  rkMem[round] <= nextW;
  end

  assign rk_out = (keysValidQ && ({28'd0, rk_idx} <= 32'(NR))) ? rkMem[rk_idx] : '0;

endmodule

// File: tb/tb_key_schedule_seq.sv
module tb_key_schedule_seq;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  key_schedule_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] k0;
    logic [127:0] k1;
    logic [127:0] k10;
  } exp_t;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_Z  = 128'h0;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  exp_t expQ[$];
  int   acceptQ[$];
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   doneCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t mkExp(input logic [127:0] k0, input logic [127:0] k1,
                                 input logic [127:0] k10);
    exp_t e;
    e.k0 = k0; e.k1 = k1; e.k10 = k10;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      acceptQ.delete();
    end else begin
      if (key_valid && key_ready) acceptQ.push_back(cyc + 1);
      if (done) begin
        logic [3:0] savedIdx;
        exp_t       e;
        doneCount++;
        chk("done_busy", busy, 0);
        chk("done_key_ready", key_ready, 0);
        chk("done_keys_valid", keys_valid, 1);
        if (acceptQ.size() == 0) chk("latency_no_accept", 1, 0);
        else chk("latency", cyc, acceptQ.pop_front() + 10);
        if (expQ.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          savedIdx = rk_idx;
          rk_idx = 4'd0;  #1 chk("rk0", rk_out, e.k0);
          rk_idx = 4'd1;  #1 chk("rk1", rk_out, e.k1);
          rk_idx = 4'd10; #1 chk("rk10", rk_out, e.k10);
          rk_idx = savedIdx;
        end
      end
    end
  end

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1; break; end
      tick(1);
    end
    if (!seen) chk({name, "_done_timeout"}, 0, 1);
  endtask

  // One full accept..FINISH..IDLE run with a single-cycle key_valid pulse.
  task automatic runKey(input string name, input logic [127:0] k, input exp_t e);
    expQ.push_back(e);
    key_in = k; key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_key_ready"}, key_ready, 0);
    chk({name, "_kv_low"}, keys_valid, 0);
    waitDone(name);
    tick(1);
    chk({name, "_idle_ready"}, key_ready, 1);
    chk({name, "_idle_done"}, done, 0);
    chk({name, "_kv_hold"}, keys_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int c0;
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_idx = 4'd0;
    tick(2);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_keys_valid", keys_valid, 0);
    chk("rst_rk_out", rk_out, 0);
    rst_n = 1'b1;
    tick(1);

    // FIPS-197 key
    runKey("keyA", KEY_A, mkExp(KEY_A, A_RK1, A_RK10));

    // all-zero key plus out-of-range indices
    runKey("keyZ", KEY_Z, mkExp(KEY_Z, Z_RK1, Z_RK10));
    for (int i = 11; i < 16; i++) begin
      rk_idx = 4'(i); #1;
      chk("idx_oob", rk_out, 0);
    end
    rk_idx = 4'd1; #1;
    chk("idx1_idle", rk_out, Z_RK1);
    rk_idx = 4'd0;
    tick(3);
    chk("kv_stays", keys_valid, 1);

    // key_valid pulse mid-expansion is ignored
    expQ.push_back(mkExp(KEY_A, A_RK1, A_RK10));
    key_in = KEY_A; key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    tick(4);
    key_in = 128'h0123456789abcdef0011223344556677; key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0; key_in = '0;
    d0 = doneCount;
    waitDone("ignore");
    tick(3);
    chk("ignore_done_once", doneCount, d0 + 1);

    // reset mid-expansion abandons the run
    expQ.push_back(mkExp(KEY_A, A_RK1, A_RK10));
    key_in = KEY_A; key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    tick(3);
    rst_n = 1'b0;
    void'(expQ.pop_back());
    tick(1);
    chk("midrst_key_ready", key_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_kv", keys_valid, 0);
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i); #1;
      chk("midrst_rk_out", rk_out, 0);
    end
    rk_idx = 4'd0;
    rst_n = 1'b1;
    d0 = doneCount;
    tick(15);
    chk("midrst_no_done", doneCount, d0);
    runKey("afterRst", KEY_Z, mkExp(KEY_Z, Z_RK1, Z_RK10));

    // back-to-back with key_valid held high: A then zero key
    expQ.push_back(mkExp(KEY_A, A_RK1, A_RK10));
    expQ.push_back(mkExp(KEY_Z, Z_RK1, Z_RK10));
    key_in = KEY_A; key_valid = 1'b1;
    tick(1);
    c0 = cyc;
    key_in = KEY_Z;
    waitDone("b2bFirst");
    tick(1);
    chk("b2b_ready", key_ready, 1);
    tick(1);
    chk("b2b_period", cyc - c0, 12);
    chk("b2b_busy", busy, 1);
    key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("b2b_kv_low", keys_valid, 0);
      tick(1);
    end
    chk("b2b_done", done, 1);
    chk("b2b_kv_high", keys_valid, 1);
    tick(3);

    chk("scoreboard_empty", expQ.size(), 0);
    chk("accepts_drained", acceptQ.size(), 0);
    chk("done_total", doneCount, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: key_in  in  128  AES-128 cipher key; key_in[127:96]=w0, byte order per FIPS-197.
REQ-004 SHALL have port: key_valid  in  1  key_in offered this cycle.
REQ-005 SHALL have port: key_ready  out  1  block accepts a key this cycle.
REQ-006 SHALL have port: busy  out  1  expansion in progress.
REQ-007 SHALL have port: done  out  1  one-cycle pulse, all 11 round keys stored.
REQ-008 SHALL have port: keys_valid  out  1  stored round-key set complete and readable.
REQ-009 SHALL have port: rk_idx  in  4  round-key read index, 0..10.
REQ-010 SHALL have port: rk_out  out  128  round key selected by rk_idx, combinational read.
REQ-011 SHALL have parameter: NR, default 10, number of rounds; sizes storage (NR+1 entries).

Function
REQ-012 SHALL implement FSM with states IDLE, EXPAND, FINISH.
REQ-013 IDLE: key_ready=1, busy=0; handshake fires on key_valid&&key_ready at a rising edge.
REQ-014 On handshake SHALL write rk[0]=key_in, set round counter=1, rcon=8'h01, clear keys_valid, enter EXPAND.
REQ-015 EXPAND: key_ready=0, busy=1; each cycle SHALL compute rk[round] from rk[round-1]: t=SubWord(RotWord(w3)) xor {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-016 Each EXPAND cycle SHALL increment round and update rcon=xtime(rcon) (shift left 1, xor 8'h1B if bit7 was set); sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-017 After writing rk[NR] SHALL enter FINISH; FINISH lasts one cycle with done=1, keys_valid=1, busy=0, key_ready=0, then IDLE.
REQ-018 Latency: handshake at edge N -> rk[10] written at edge N+10 -> done high during cycle N+10..N+11 only.
REQ-019 keys_valid SHALL stay 1 from FINISH until next accepted handshake or reset.
REQ-020 key_valid while busy or in FINISH SHALL be ignored (no effect, key not latched).
REQ-021 rk_out SHALL equal rk[rk_idx] when keys_valid=1 and rk_idx<=NR; 128'h0 when keys_valid=0 or rk_idx>NR.
REQ-022 Back-to-back: key_valid held high SHALL be accepted again in the first IDLE cycle after FINISH (period 12 cycles).

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE, round=0, rcon=8'h01, keys_valid=0, done=0, busy=0; key_ready=1 from the next cycle.
REQ-024 Reset mid-EXPAND SHALL abandon the expansion; partially written storage need not be cleared (masked by REQ-021).
REQ-025 Round-key storage SHALL NOT require reset.

Structure
REQ-026 Shared package aes_pkg SHALL hold NR, Nk=4, RCON_INIT=8'h01, xtime polynomial 8'h1B, FSM state enum.
REQ-027 SHALL instantiate four copies of sub-module aes_sbox (8-bit in, 8-bit out, combinational) for SubWord; no other sub-modules.
REQ-028 Storage SHALL be a register array of NR+1 x 128 bits; one write per cycle.

Verification
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c -> done 10 cycles after accept; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 Key all-zero -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e; rk_idx=11..15 -> rk_out=0.
REQ-031 Second key_valid pulse with new key during EXPAND cycle 5 -> ignored; results equal first key's vectors; done pulses once.
REQ-032 rst_n=0 during EXPAND cycle 4 -> next cycle IDLE, keys_valid=0, rk_out=0 for all idx, done never pulses; new key then expands correctly.
REQ-033 key_valid held high with keys A then B -> accepts at cycles 0 and 12; keys_valid low cycles 1..10 of second run; final rk set matches B.
